// File: rtl/joy_db15_tx.sv
// Device end of the DB15 adapter serial link. On load it captures both players'
// buttons and shifts them out active-low, one bit per JOY_CLK rising edge.
module joy_db15_tx #(
  parameter int NBITS       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             joy_clk_in,
  input  logic             joy_load_in,
  output logic             joy_data_out,
  input  logic [NBITS-1:0] joystick1,
  input  logic [NBITS-1:0] joystick2,
  output logic             busy,
  output logic             frame_done
);

  localparam int FRAME = 2 * NBITS;
  localparam int CNT_W = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  function automatic logic [FRAME-1:0] load_word(input logic [NBITS-1:0] j1,
                                                  input logic [NBITS-1:0] j2);
    return ~{j2, j1};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_d;
  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;

  state_t           state_p0, state_nxt;
  logic [FRAME-1:0] sreg_p0, sreg_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             done_p0, done_nxt;

  logic data_p1;
  logic busy_p1;
  logic done_p1;

  // Input synchronizers and clock edge detect; idle level of both lines is high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      load_sync <= '1;
      clk_d     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk_in};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load_in};
      clk_d     <= clk_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign load_s   = load_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;

  // Load has priority over everything, so an abort or a coincident clock edge never shifts
  always_comb begin
    state_nxt = state_p0;
    sreg_nxt  = sreg_p0;
    cnt_nxt   = cnt_p0;
    done_nxt  = 1'b0;
    if (!load_s) begin
      state_nxt = LOAD;
      sreg_nxt  = load_word(joystick1, joystick2);
      cnt_nxt   = '0;
    end else begin
      case (state_p0)
        IDLE: sreg_nxt = '1;
        LOAD: state_nxt = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            sreg_nxt = {1'b1, sreg_p0[FRAME-1:1]};
            cnt_nxt  = cnt_p0 + CNT_W'(1);
            if (cnt_p0 == CNT_W'(FRAME - 1)) begin
              state_nxt = DONE;
              sreg_nxt  = '1;
              done_nxt  = 1'b1;
            end
          end
        end
        DONE: sreg_nxt = '1;
        default: begin
          state_nxt = IDLE;
          sreg_nxt  = '1;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Stage p0: protocol state, shift register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      sreg_p0  <= '1;
      cnt_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      sreg_p0  <= sreg_nxt;
      cnt_p0   <= cnt_nxt;
      done_p0  <= done_nxt;
    end
  end

  // Stage p1: registered outputs, so data, busy and frame_done change together
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= 1'b1;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      data_p1 <= sreg_p0[0];
      busy_p1 <= (state_p0 == LOAD) || (state_p0 == SHIFT);
      done_p1 <= done_p0;
    end
  end

  assign joy_data_out = data_p1;
  assign busy         = busy_p1;
  assign frame_done   = done_p1;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: acts as the DB15 reader, scoreboarding expected serial
// bits computed from the joystick words against what the reader samples.
module tb_joy_db15_tx;

  localparam int NBITS = 12;
  localparam int FRAME = 2 * NBITS;
  localparam int HALF  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             joy_clk_in;
  logic             joy_load_in;
  logic             joy_data_out;
  logic [NBITS-1:0] joystick1;
  logic [NBITS-1:0] joystick2;
  logic             busy;
  logic             frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic exp_q[$];

  joy_db15_tx #(.NBITS(NBITS), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .joy_clk_in   (joy_clk_in),
    .joy_load_in  (joy_load_in),
    .joy_data_out (joy_data_out),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [NBITS-1:0] j1, input logic [NBITS-1:0] j2);
    joystick1   = j1;
    joystick2   = j2;
    joy_load_in = 1'b0;
    wait_cyc(HALF);
    joy_load_in = 1'b1;
    wait_cyc(HALF);
  endtask

  // Reader loop: sample before each rise, compare against the model bit
  task automatic shift_frame(input string tag, input int nedges);
    logic [FRAME-1:0] w;
    logic e;
    w = {joystick2, joystick1};
    for (int k = 0; k <= nedges; k++) begin
      exp_q.push_back((k < FRAME) ? ~w[k] : 1'b1);
      e = exp_q.pop_front();
      check($sformatf("%s_bit%0d", tag, k), {31'b0, joy_data_out}, {31'b0, e});
      if (k == nedges) break;
      joy_clk_in = 1'b1;
      wait_cyc(HALF);
      joy_clk_in = 1'b0;
      wait_cyc(HALF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset       = 1'b1;
    joy_load_in = 1'b0;
    joy_clk_in  = 1'b0;
    joystick1   = 12'h005;
    joystick2   = 12'h800;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out", {31'b0, joy_data_out}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, frame_done}, 32'd0);
      joy_clk_in = ~joy_clk_in;
    end
    reset      = 1'b0;
    joy_clk_in = 1'b0;
    wait_cyc(3);
    check("rel_idle_busy", {31'b0, busy}, 32'd0);
    check("rel_idle_out", {31'b0, joy_data_out}, 32'd1);
    wait_cyc(3);
    check("rel_load_busy", {31'b0, busy}, 32'd1);
    check("rel_load_out", {31'b0, joy_data_out}, 32'd0);
    joy_load_in = 1'b1;
    wait_cyc(HALF);

    // Nominal frame
    d0 = done_cnt;
    do_load(12'h005, 12'h800);
    check("nom_busy", {31'b0, busy}, 32'd1);
    shift_frame("nom", FRAME);
    check("nom_done", done_cnt - d0, 32'd1);
    check("nom_busy_end", {31'b0, busy}, 32'd0);

    // Over-clock past the end of the frame
    d0 = done_cnt;
    do_load(12'hA5C, 12'h3C1);
    shift_frame("ovr", 30);
    check("ovr_done", done_cnt - d0, 32'd1);

    // Mid-frame abort with new buttons
    d0 = done_cnt;
    do_load(12'h005, 12'h000);
    shift_frame("abt", 10);
    joystick1   = 12'hFFF;
    joy_load_in = 1'b0;
    wait_cyc(4);
    check("abt_out", {31'b0, joy_data_out}, 32'd0);
    check("abt_busy", {31'b0, busy}, 32'd1);
    wait_cyc(HALF);
    joy_load_in = 1'b1;
    wait_cyc(HALF);
    check("abt_nodone", done_cnt - d0, 32'd0);
    shift_frame("abt2", FRAME);
    check("abt2_done", done_cnt - d0, 32'd1);

    // Load fall and clock rise in the same synchronized cycle (from DONE)
    d0 = done_cnt;
    joystick1   = 12'h6B1;
    joystick2   = 12'h0F0;
    joy_load_in = 1'b0;
    joy_clk_in  = 1'b1;
    wait_cyc(HALF);
    check("sim_out", {31'b0, joy_data_out}, 32'd0);
    joy_clk_in = 1'b0;
    wait_cyc(HALF);
    joy_load_in = 1'b1;
    wait_cyc(HALF);
    shift_frame("sim", FRAME);
    check("sim_done", done_cnt - d0, 32'd1);

    // One-cycle JOY_CLK pulse: at most one shift
    d0 = done_cnt;
    do_load(12'h003, 12'h000);
    joy_clk_in = 1'b1;
    wait_cyc(1);
    joy_clk_in = 1'b0;
    wait_cyc(HALF);
    check("short_out", {31'b0, joy_data_out}, 32'd0);
    for (int k = 0; k < FRAME - 1; k++) begin
      joy_clk_in = 1'b1;
      wait_cyc(HALF);
      joy_clk_in = 1'b0;
      wait_cyc(HALF);
    end
    if (done_cnt == d0) begin
      check("short_busy_mid", {31'b0, busy}, 32'd1);
      joy_clk_in = 1'b1;
      wait_cyc(HALF);
      joy_clk_in = 1'b0;
      wait_cyc(HALF);
    end
    check("short_done", done_cnt - d0, 32'd1);
    check("short_busy", {31'b0, busy}, 32'd0);
    check("short_out_end", {31'b0, joy_data_out}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
